// File: rtl/hdmi_stream_scoreboard.sv
// hdmi_stream_scoreboard: passive checker for valid/ready HDMI pixel streams.
// It queues the input-side {hsync,vsync,vde} metadata and compares it in order
// against the output side. It also counts checked pixels, builds a per-frame
// XOR checksum, and flags overflow, underflow and output inactivity.
// Optional build macro SB_FIRST_ERR_EN adds capture ports for the first
// metadata mismatch.
module hdmi_stream_scoreboard #(
  parameter int NUM_CH  = 3,
  parameter int COLOR_W = 8,
  parameter int DEPTH   = 64,
  parameter int TIMEOUT = 20736000,
  parameter int CNT_W   = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        in_valid_i,
  input  logic                        in_ready_i,
  input  logic [2:0]                  in_meta_i,
  input  logic                        out_valid_i,
  input  logic                        out_ready_i,
  input  logic [2:0]                  out_meta_i,
  input  logic [NUM_CH*COLOR_W-1:0]   out_data_i,
  output logic [CNT_W-1:0]            n_checks_o,
  output logic [CNT_W-1:0]            n_meta_errs_o,
  output logic [$clog2(DEPTH):0]      fifo_level_o,
  output logic [NUM_CH*COLOR_W-1:0]   checksum_o,
  output logic                        checksum_valid_o,
  output logic                        overflow_o,
  output logic                        underflow_o,
  output logic                        timeout_o
`ifdef SB_FIRST_ERR_EN
  ,
  output logic                        first_err_valid_o,
  output logic [CNT_W-1:0]            first_err_idx_o,
  output logic [2:0]                  first_err_exp_o,
  output logic [2:0]                  first_err_act_o
`endif
);

  localparam int PIX_W = NUM_CH * COLOR_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [LW-1:0]    DEPTH_C   = LW'(DEPTH);

  // Saturating increment shared by every counter in the block.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [2:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] n_checks_q, n_checks_d;
  logic [CNT_W-1:0] n_errs_q, n_errs_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic [PIX_W-1:0] acc_q, acc_d;
  logic [PIX_W-1:0] checksum_q, checksum_d;
  logic             cs_valid_q, cs_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             timeout_q, timeout_d;
  logic             vsync_seen_q, vsync_seen_d;
  logic             prev_vsync_q, prev_vsync_d;

  logic in_fire, out_fire, full, empty, push, pop, check, boundary, mismatch;
  logic [2:0] head;

  assign in_fire  = in_valid_i & in_ready_i;
  assign out_fire = out_valid_i & out_ready_i;
  assign full     = (level_q == DEPTH_C);
  assign empty    = (level_q == '0);
  // When full, a push is only accepted if a pop frees the slot this cycle.
  assign push     = in_fire & (~full | out_fire);
  // No bypass: an entry pushed into an empty queue is not visible to a same-cycle pop.
  assign pop      = out_fire & ~empty;
  assign head     = mem_q[rd_ptr_q];
  assign mismatch = pop & (head != out_meta_i);
  assign check    = out_fire & out_meta_i[0] & (vsync_seen_q | out_meta_i[1]);
  assign boundary = out_fire & out_meta_i[1] & ~prev_vsync_q;

  // Next-state for queue control, counters, checksum and sticky flags.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    n_checks_d   = n_checks_q;
    n_errs_d     = n_errs_q;
    idle_d       = idle_q;
    acc_d        = acc_q;
    checksum_d   = checksum_q;
    cs_valid_d   = 1'b0;
    overflow_d   = overflow_q | (in_fire & full & ~out_fire);
    underflow_d  = underflow_q | (out_fire & empty);
    vsync_seen_d = vsync_seen_q | (out_fire & out_meta_i[1]);
    prev_vsync_d = out_fire ? out_meta_i[1] : prev_vsync_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (mismatch) n_errs_d = sat_inc(n_errs_q);
    if (check)    n_checks_d = sat_inc(n_checks_q);

    // The boundary beat's own pixel opens the new frame.
    if (boundary) begin
      checksum_d = acc_q;
      cs_valid_d = 1'b1;
      acc_d      = check ? out_data_i : '0;
    end else if (check) begin
      acc_d = acc_q ^ out_data_i;
    end

    if (out_fire)                idle_d = '0;
    else if (idle_q != TIMEOUT_C) idle_d = sat_inc(idle_q);
    timeout_d = timeout_q | (~out_fire & (idle_d == TIMEOUT_C));
  end

  // Control and result registers; reset clears everything, including mid-frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      n_checks_q   <= '0;
      n_errs_q     <= '0;
      idle_q       <= '0;
      acc_q        <= '0;
      checksum_q   <= '0;
      cs_valid_q   <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      timeout_q    <= 1'b0;
      vsync_seen_q <= 1'b0;
      prev_vsync_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      n_checks_q   <= n_checks_d;
      n_errs_q     <= n_errs_d;
      idle_q       <= idle_d;
      acc_q        <= acc_d;
      checksum_q   <= checksum_d;
      cs_valid_q   <= cs_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      timeout_q    <= timeout_d;
      vsync_seen_q <= vsync_seen_d;
      prev_vsync_q <= prev_vsync_d;
    end
  end

  // Metadata storage; emptiness is tracked by the pointers, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_meta_i;
  end

  assign n_checks_o       = n_checks_q;
  assign n_meta_errs_o    = n_errs_q;
  assign fifo_level_o     = level_q;
  assign checksum_o       = checksum_q;
  assign checksum_valid_o = cs_valid_q;
  assign overflow_o       = overflow_q;
  assign underflow_o      = underflow_q;
  assign timeout_o        = timeout_q;

`ifdef SB_FIRST_ERR_EN
  logic [CNT_W-1:0] fire_idx_q, fire_idx_d;
  logic             fe_valid_q, fe_valid_d;
  logic [CNT_W-1:0] fe_idx_q, fe_idx_d;
  logic [2:0]       fe_exp_q, fe_exp_d;
  logic [2:0]       fe_act_q, fe_act_d;

  // Capture only the first mismatch; its index counts all out_fires from 0.
  always_comb begin
    fire_idx_d = out_fire ? sat_inc(fire_idx_q) : fire_idx_q;
    fe_valid_d = fe_valid_q;
    fe_idx_d   = fe_idx_q;
    fe_exp_d   = fe_exp_q;
    fe_act_d   = fe_act_q;
    if (mismatch && !fe_valid_q) begin
      fe_valid_d = 1'b1;
      fe_idx_d   = fire_idx_q;
      fe_exp_d   = head;
      fe_act_d   = out_meta_i;
    end
  end

  // First-error capture registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fire_idx_q <= '0;
      fe_valid_q <= 1'b0;
      fe_idx_q   <= '0;
      fe_exp_q   <= '0;
      fe_act_q   <= '0;
    end else begin
      fire_idx_q <= fire_idx_d;
      fe_valid_q <= fe_valid_d;
      fe_idx_q   <= fe_idx_d;
      fe_exp_q   <= fe_exp_d;
      fe_act_q   <= fe_act_d;
    end
  end

  assign first_err_valid_o = fe_valid_q;
  assign first_err_idx_o   = fe_idx_q;
  assign first_err_exp_o   = fe_exp_q;
  assign first_err_act_o   = fe_act_q;
`endif

endmodule

// File: tb/tb_hdmi_stream_scoreboard.sv
// Directed bench for hdmi_stream_scoreboard. Two instances share the stimulus:
// u_big (DEPTH=16, TIMEOUT=64) for stream checks, u_small (DEPTH=4, TIMEOUT=16)
// for queue limits and inactivity.
module tb_hdmi_stream_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_ready = 1'b1;
  logic [2:0]  in_meta = 3'b000;
  logic        out_valid = 1'b0, out_ready = 1'b1;
  logic [2:0]  out_meta = 3'b000;
  logic [23:0] out_data = 24'h0;

  logic [31:0] b_checks, b_errs, s_checks, s_errs;
  logic [4:0]  b_level;
  logic [2:0]  s_level;
  logic [23:0] b_cs, s_cs;
  logic        b_csv, b_ovf, b_udf, b_to, s_csv, s_ovf, s_udf, s_to;
`ifdef SB_FIRST_ERR_EN
  logic        b_fev, s_fev;
  logic [31:0] b_fei, s_fei;
  logic [2:0]  b_fee, b_fea, s_fee, s_fea;
`endif

  int vectors = 0;
  int miscompares = 0;

  hdmi_stream_scoreboard #(.NUM_CH(3), .COLOR_W(8), .DEPTH(16), .TIMEOUT(64), .CNT_W(32)) u_big (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_i(in_ready), .in_meta_i(in_meta),
    .out_valid_i(out_valid), .out_ready_i(out_ready), .out_meta_i(out_meta), .out_data_i(out_data),
    .n_checks_o(b_checks), .n_meta_errs_o(b_errs), .fifo_level_o(b_level),
    .checksum_o(b_cs), .checksum_valid_o(b_csv),
    .overflow_o(b_ovf), .underflow_o(b_udf), .timeout_o(b_to)
`ifdef SB_FIRST_ERR_EN
    , .first_err_valid_o(b_fev), .first_err_idx_o(b_fei),
    .first_err_exp_o(b_fee), .first_err_act_o(b_fea)
`endif
  );

  hdmi_stream_scoreboard #(.NUM_CH(3), .COLOR_W(8), .DEPTH(4), .TIMEOUT(16), .CNT_W(32)) u_small (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_i(in_ready), .in_meta_i(in_meta),
    .out_valid_i(out_valid), .out_ready_i(out_ready), .out_meta_i(out_meta), .out_data_i(out_data),
    .n_checks_o(s_checks), .n_meta_errs_o(s_errs), .fifo_level_o(s_level),
    .checksum_o(s_cs), .checksum_valid_o(s_csv),
    .overflow_o(s_ovf), .underflow_o(s_udf), .timeout_o(s_to)
`ifdef SB_FIRST_ERR_EN
    , .first_err_valid_o(s_fev), .first_err_idx_o(s_fei),
    .first_err_exp_o(s_fee), .first_err_act_o(s_fea)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given handshake activity; outputs are read 1 time unit after the edge.
  task automatic beat(input logic iv, input logic [2:0] im, input logic ov,
                      input logic [2:0] om, input logic [23:0] d);
    in_valid = iv; in_meta = im; out_valid = ov; out_meta = om; out_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0; out_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    do_reset();
    check("rst_checks", b_checks, 32'd0);
    check("rst_level", 32'(b_level), 32'd0);
    check("rst_checksum", 32'(b_cs), 32'd0);

    // T1: ten matching entries through the queue
    for (int i = 0; i < 10; i++) beat(1'b1, 3'b001, 1'b0, 3'b000, 24'h0);
    check("t1_level_full", 32'(b_level), 32'd10);
    for (int i = 0; i < 10; i++) beat(1'b0, 3'b000, 1'b1, 3'b001, 24'h0);
    check("t1_errs", b_errs, 32'd0);
    check("t1_level_empty", 32'(b_level), 32'd0);
    check("t1_flags", {29'd0, b_ovf, b_udf, b_to}, 32'd0);
    check("t1_no_checks", b_checks, 32'd0);
    in_ready = 1'b0;
    beat(1'b1, 3'b001, 1'b0, 3'b000, 24'h0);
    in_ready = 1'b1;
    check("t1_no_fire_no_push", 32'(b_level), 32'd0);

    // T2: mismatch and first-error capture
    do_reset();
    beat(1'b1, 3'b101, 1'b0, 3'b000, 24'h0);
    beat(1'b0, 3'b000, 1'b1, 3'b001, 24'h0);
    check("t2_errs", b_errs, 32'd1);
`ifdef SB_FIRST_ERR_EN
    check("t2_fe_valid", 32'(b_fev), 32'd1);
    check("t2_fe_idx", b_fei, 32'd0);
    check("t2_fe_exp", 32'(b_fee), 32'd5);
    check("t2_fe_act", 32'(b_fea), 32'd1);
`endif
    beat(1'b1, 3'b110, 1'b0, 3'b000, 24'h0);
    beat(1'b0, 3'b000, 1'b1, 3'b000, 24'h0);
    check("t2_errs2", b_errs, 32'd2);
`ifdef SB_FIRST_ERR_EN
    check("t2_fe_idx_kept", b_fei, 32'd0);
    check("t2_fe_exp_kept", 32'(b_fee), 32'd5);
`endif

    // T3: pixels are only checked once a vsync has been seen
    do_reset();
    for (int i = 0; i < 5; i++) beat(1'b0, 3'b000, 1'b1, 3'b001, 24'h000011);
    check("t3_pre_vsync", b_checks, 32'd0);
    beat(1'b0, 3'b000, 1'b1, 3'b010, 24'h0);
    for (int i = 0; i < 4; i++) beat(1'b0, 3'b000, 1'b1, 3'b001, 24'h000011);
    check("t3_post_vsync", b_checks, 32'd4);

    // T4: per-frame XOR checksum
    do_reset();
    beat(1'b0, 3'b000, 1'b1, 3'b010, 24'h0);
    check("t4_first_boundary_pulse", 32'(b_csv), 32'd1);
    beat(1'b0, 3'b000, 1'b1, 3'b001, 24'h010203);
    check("t4_pulse_one_cycle0", 32'(b_csv), 32'd0);
    beat(1'b0, 3'b000, 1'b1, 3'b001, 24'h0000FF);
    beat(1'b0, 3'b000, 1'b1, 3'b011, 24'h0F0F0F);
    check("t4_checksum", 32'(b_cs), 32'h0102FC);
    check("t4_pulse", 32'(b_csv), 32'd1);
    idle(1);
    check("t4_pulse_one_cycle", 32'(b_csv), 32'd0);
    beat(1'b0, 3'b000, 1'b1, 3'b010, 24'h0);
    check("t4_held_vsync_no_pulse", 32'(b_csv), 32'd0);
    beat(1'b0, 3'b000, 1'b1, 3'b001, 24'h000001);
    beat(1'b0, 3'b000, 1'b1, 3'b010, 24'h0);
    check("t4_boundary_pixel_new_frame", 32'(b_cs), 32'h0F0F0E);
    check("t4_checks", b_checks, 32'd4);

    // T5: DEPTH=4 overflow, simultaneous push/pop when full, underflow
    do_reset();
    beat(1'b1, 3'b001, 1'b0, 3'b000, 24'h0);
    beat(1'b1, 3'b010, 1'b0, 3'b000, 24'h0);
    beat(1'b1, 3'b011, 1'b0, 3'b000, 24'h0);
    beat(1'b1, 3'b100, 1'b0, 3'b000, 24'h0);
    beat(1'b1, 3'b101, 1'b1, 3'b001, 24'h0);
    check("t5_full_pushpop_level", 32'(s_level), 32'd4);
    check("t5_full_pushpop_no_ovf", 32'(s_ovf), 32'd0);
    beat(1'b1, 3'b111, 1'b0, 3'b000, 24'h0);
    check("t5_overflow", 32'(s_ovf), 32'd1);
    check("t5_level", 32'(s_level), 32'd4);
    beat(1'b0, 3'b000, 1'b1, 3'b010, 24'h0);
    beat(1'b0, 3'b000, 1'b1, 3'b011, 24'h0);
    beat(1'b0, 3'b000, 1'b1, 3'b100, 24'h0);
    beat(1'b0, 3'b000, 1'b1, 3'b101, 24'h0);
    check("t5_drain_errs", s_errs, 32'd0);
    check("t5_no_underflow_yet", 32'(s_udf), 32'd0);
    beat(1'b0, 3'b000, 1'b1, 3'b001, 24'h0);
    check("t5_underflow", 32'(s_udf), 32'd1);
    check("t5_underflow_no_err", s_errs, 32'd0);

    // T6: TIMEOUT=16 inactivity, then reset mid-run
    do_reset();
    idle(15);
    check("t6_no_timeout_15", 32'(s_to), 32'd0);
    idle(1);
    check("t6_timeout_16", 32'(s_to), 32'd1);
    beat(1'b1, 3'b001, 1'b0, 3'b000, 24'h0);
    beat(1'b1, 3'b010, 1'b0, 3'b000, 24'h0);
    beat(1'b0, 3'b000, 1'b1, 3'b111, 24'h0);
    check("t6_pre_reset_errs", s_errs, 32'd1);
    do_reset();
    check("t6_rst_checks", s_checks, 32'd0);
    check("t6_rst_errs", s_errs, 32'd0);
    check("t6_rst_level", 32'(s_level), 32'd0);
    check("t6_rst_checksum", 32'(s_cs), 32'd0);
    check("t6_rst_flags", {28'd0, s_csv, s_ovf, s_udf, s_to}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
